// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and forwarding helper for the hazard unit
package hazard_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = 2'b00;
    localparam fwd_sel_t FWD_W  = 2'b01;
    localparam fwd_sel_t FWD_M  = 2'b10;

    localparam logic [3:0] REG_PC = 4'd15;

    // The PC is never forwarded; Memory-stage result wins over Writeback.
    function automatic fwd_sel_t fwd_select(
        input logic [3:0] ra,
        input logic [3:0] wa_m,
        input logic [3:0] wa_w,
        input logic       we_m,
        input logic       we_w
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (ra != REG_PC) begin
            if (we_m && (wa_m == ra)) begin
                sel = FWD_M;
            end else if (we_w && (wa_w == ra)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    import hazard_pkg::*;

    logic [3:0]       RA1D;
    logic [3:0]       RA2D;
    logic [3:0]       RA1E;
    logic [3:0]       RA2E;
    logic [3:0]       WA3E;
    logic [3:0]       WA3M;
    logic [3:0]       WA3W;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemtoRegE;
    logic             PCSrcD;
    logic             PCSrcW;
    logic             BranchTakenE;
    logic             perf_clr;

    fwd_sel_t         ForwardAE;
    fwd_sel_t         ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcW, BranchTakenE, perf_clr,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, stall_cnt, flush_cnt
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcW, BranchTakenE, perf_clr,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hz_sat_counter.sv
// rtl/hz_sat_counter.sv - saturating event counter with synchronous clear
module hz_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Clear beats increment; the count sticks at all-ones once reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding, stall and flush control for the 5-stage pipeline
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_unit_if.slave hz
);

    logic ld_stall;
    logic pend_e;
    logic pend_m;
    logic pc_wr_pending;
    logic flush_e_raw;
    logic flush_d_raw;
    logic stall_f_raw;

    // Raw hazard terms before the reset override is applied.
    always_comb begin
        ld_stall      = hz.MemtoRegE && ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));
        pc_wr_pending = hz.PCSrcD | pend_e | pend_m;
        stall_f_raw   = ld_stall | pc_wr_pending;
        flush_d_raw   = pc_wr_pending | hz.PCSrcW | hz.BranchTakenE;
        flush_e_raw   = ld_stall | hz.BranchTakenE;
    end

    // Outputs; while in reset, bubble D and E so the unreset control pipe drains.
    always_comb begin
        hz.ForwardAE = FWD_RF;
        hz.ForwardBE = FWD_RF;
        hz.StallF    = 1'b0;
        hz.StallD    = 1'b0;
        hz.FlushD    = 1'b1;
        hz.FlushE    = 1'b1;
        if (reset) begin
            hz.ForwardAE = fwd_select(hz.RA1E, hz.WA3M, hz.WA3W, hz.RegWriteM, hz.RegWriteW);
            hz.ForwardBE = fwd_select(hz.RA2E, hz.WA3M, hz.WA3W, hz.RegWriteM, hz.RegWriteW);
            hz.StallF    = stall_f_raw;
            hz.StallD    = ld_stall;
            hz.FlushD    = flush_d_raw;
            hz.FlushE    = flush_e_raw;
        end
    end

    // Shadow of a PC-writing instruction moving through E and M; a flushed D never enters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_e <= 1'b0;
            pend_m <= 1'b0;
        end else begin
            pend_e <= flush_e_raw ? 1'b0 : hz.PCSrcD;
            pend_m <= pend_e;
        end
    end

    hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (hz.perf_clr),
        .inc   (hz.StallF),
        .count (hz.stall_cnt)
    );

    hz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (hz.perf_clr),
        .inc   (flush_e_raw),
        .count (hz.flush_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;
    import hazard_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(CW)) hz ();

    hazard_unit #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .hz    (hz)
    );

    typedef struct {
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       rwm, rww, mtr, pcd, pcw, br, clr;
        logic [1:0] fa, fb;
        logic       sf, sd, fd, fe;
    } vec_t;

    typedef struct {
        logic [1:0] fa, fb;
        logic       sf, sd, fd, fe;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    passed = 0;
    vec_t  tbl[13];

    function automatic vec_t mk(
        input logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w,
        input logic rwm, rww, mtr, pcd, pcw, br, clr,
        input logic [1:0] fa, fb,
        input logic sf, sd, fd, fe
    );
        vec_t v;
        v.ra1d = ra1d; v.ra2d = ra2d; v.ra1e = ra1e; v.ra2e = ra2e;
        v.wa3e = wa3e; v.wa3m = wa3m; v.wa3w = wa3w;
        v.rwm = rwm; v.rww = rww; v.mtr = mtr; v.pcd = pcd; v.pcw = pcw; v.br = br; v.clr = clr;
        v.fa = fa; v.fb = fb; v.sf = sf; v.sd = sd; v.fd = fd; v.fe = fe;
        return v;
    endfunction

    // idle inputs except for the PC/branch/clear controls, with expected stall/flush
    function automatic vec_t ctl(
        input logic pcd, pcw, br, clr,
        input logic sf, fd, fe
    );
        return mk(0,0,0,0,0,0,0, 0,0,0,pcd,pcw,br,clr, 2'b00,2'b00, sf,1'b0,fd,fe);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        hz.RA1D = v.ra1d; hz.RA2D = v.ra2d; hz.RA1E = v.ra1e; hz.RA2E = v.ra2e;
        hz.WA3E = v.wa3e; hz.WA3M = v.wa3m; hz.WA3W = v.wa3w;
        hz.RegWriteM = v.rwm; hz.RegWriteW = v.rww; hz.MemtoRegE = v.mtr;
        hz.PCSrcD = v.pcd; hz.PCSrcW = v.pcw; hz.BranchTakenE = v.br; hz.perf_clr = v.clr;
    endtask

    task automatic compare_out(input string nm);
        exp_t e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk({n, ".ForwardAE"}, 32'(hz.ForwardAE), 32'(e.fa));
        chk({n, ".ForwardBE"}, 32'(hz.ForwardBE), 32'(e.fb));
        chk({n, ".StallF"},    32'(hz.StallF),    32'(e.sf));
        chk({n, ".StallD"},    32'(hz.StallD),    32'(e.sd));
        chk({n, ".FlushD"},    32'(hz.FlushD),    32'(e.fd));
        chk({n, ".FlushE"},    32'(hz.FlushE),    32'(e.fe));
    endtask

    // one pipeline cycle: drive after the edge, expectation queued, compared mid-cycle
    task automatic step(input vec_t v, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        drive(v);
        e.fa = v.fa; e.fb = v.fb; e.sf = v.sf; e.sd = v.sd; e.fd = v.fd; e.fe = v.fe;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        compare_out(nm);
    endtask

    task automatic chk_cnt(input string nm, input int s, input int f);
        chk({nm, ".stall_cnt"}, 32'(hz.stall_cnt), 32'(s));
        chk({nm, ".flush_cnt"}, 32'(hz.flush_cnt), 32'(f));
    endtask

    initial begin
        //             ra1d ra2d ra1e ra2e wa3e wa3m wa3w rwm rww mtr pcd pcw br clr  fa     fb    sf sd fd fe
        tbl[0]  = mk(0, 0, 3, 0, 0, 3, 3,   1,1,0,0,0,0,0, 2'b10,2'b00, 0,0,0,0);
        tbl[1]  = mk(0, 0, 3, 0, 0, 3, 3,   0,1,0,0,0,0,0, 2'b01,2'b00, 0,0,0,0);
        tbl[2]  = mk(0, 0, 15,0, 0, 15,15,  1,1,0,0,0,0,0, 2'b00,2'b00, 0,0,0,0);
        tbl[3]  = mk(0, 0, 0, 7, 0, 7, 7,   1,1,0,0,0,0,0, 2'b00,2'b10, 0,0,0,0);
        tbl[4]  = mk(0, 0, 7, 7, 0, 7, 7,   0,1,0,0,0,0,0, 2'b01,2'b01, 0,0,0,0);
        tbl[5]  = mk(0, 0, 0, 15,0, 0, 15,  0,1,0,0,0,0,0, 2'b00,2'b00, 0,0,0,0);
        tbl[6]  = mk(0, 0, 2, 4, 0, 2, 4,   1,1,0,0,0,0,0, 2'b10,2'b01, 0,0,0,0);
        tbl[7]  = mk(5, 0, 0, 0, 5, 0, 0,   0,0,1,0,0,0,0, 2'b00,2'b00, 1,1,0,1);
        tbl[8]  = mk(5, 0, 0, 0, 5, 0, 0,   0,0,0,0,0,0,0, 2'b00,2'b00, 0,0,0,0);
        tbl[9]  = mk(5, 4, 0, 0, 6, 0, 0,   0,0,1,0,0,0,0, 2'b00,2'b00, 0,0,0,0);
        tbl[10] = ctl(0,1,0,0, 0,1,0);
        tbl[11] = ctl(0,0,1,0, 0,1,1);
        tbl[12] = ctl(0,0,0,0, 0,0,0);

        // reset state: override outputs even with a forwarding match present
        drive(mk(0,0,3,3,0,3,3, 1,1,0,1,0,0,0, 2'b00,2'b00, 0,0,0,0));
        @(negedge clk);
        chk("rst.ForwardAE", 32'(hz.ForwardAE), 32'(FWD_RF));
        chk("rst.ForwardBE", 32'(hz.ForwardBE), 32'(FWD_RF));
        chk("rst.StallF", 32'(hz.StallF), 32'd0);
        chk("rst.StallD", 32'(hz.StallD), 32'd0);
        chk("rst.FlushD", 32'(hz.FlushD), 32'd1);
        chk("rst.FlushE", 32'(hz.FlushE), 32'd1);
        chk_cnt("rst", 0, 0);
        drive(ctl(0,0,0,0, 0,0,0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) step(tbl[i], $sformatf("vec%0d", i));

        // load-use: exactly one stall cycle, counters advance by one
        step(ctl(0,0,0,1, 0,0,0), "lu_clr");
        step(mk(0,5,0,0,5,0,0, 0,0,1,0,0,0,0, 2'b00,2'b00, 1,1,0,1), "lu_stall");
        chk_cnt("lu_before", 0, 0);
        step(ctl(0,0,0,0, 0,0,0), "lu_bubble");
        chk_cnt("lu_after", 1, 1);

        // PC write committed in cycle 3
        step(ctl(0,0,0,1, 0,0,0), "pcw_clr");
        step(ctl(1,0,0,0, 1,1,0), "pcw_c0");
        step(ctl(0,0,0,0, 1,1,0), "pcw_c1");
        step(ctl(0,0,0,0, 1,1,0), "pcw_c2");
        step(ctl(0,1,0,0, 0,1,0), "pcw_c3");
        step(ctl(0,0,0,0, 0,0,0), "pcw_c4");
        chk_cnt("pcw", 3, 0);

        // PC write cancelled: fetch resumes in cycle 3
        step(ctl(1,0,0,0, 1,1,0), "pcx_c0");
        step(ctl(0,0,0,0, 1,1,0), "pcx_c1");
        step(ctl(0,0,0,0, 1,1,0), "pcx_c2");
        step(ctl(0,0,0,0, 0,0,0), "pcx_c3");

        // taken branch kills the PC-writing D instruction
        step(ctl(1,0,1,0, 1,1,1), "bk_c0");
        step(ctl(0,0,0,0, 0,0,0), "bk_c1");
        step(ctl(0,0,0,0, 0,0,0), "bk_c2");

        // load-use together with PCSrcD: D is held and re-evaluated next cycle
        step(mk(5,0,0,0,5,0,0, 0,0,1,1,0,0,0, 2'b00,2'b00, 1,1,1,1), "lp_c0");
        step(ctl(1,0,0,0, 1,1,0), "lp_c1");
        step(ctl(0,0,0,0, 1,1,0), "lp_c2");
        step(ctl(0,0,0,0, 1,1,0), "lp_c3");
        step(ctl(0,0,0,0, 0,0,0), "lp_c4");

        // asynchronous reset in the middle of a PC write
        step(ctl(1,0,0,0, 1,1,0), "ar_c0");
        @(posedge clk);
        #1;
        drive(mk(0,0,3,3,0,3,3, 1,1,0,0,0,0,0, 2'b00,2'b00, 0,0,0,0));
        rst_n = 1'b0;
        #1;
        chk("ar.ForwardAE", 32'(hz.ForwardAE), 32'(FWD_RF));
        chk("ar.StallF", 32'(hz.StallF), 32'd0);
        chk("ar.FlushD", 32'(hz.FlushD), 32'd1);
        chk("ar.FlushE", 32'(hz.FlushE), 32'd1);
        chk_cnt("ar", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(ctl(0,0,0,0, 0,0,0), "ar_after");
        step(ctl(0,0,0,0, 0,0,0), "ar_after2");

        // saturation and clear-over-increment
        step(ctl(0,0,0,1, 0,0,0), "sat_clr");
        for (int i = 0; i < 20; i++) step(ctl(1,0,0,0, 1,1,0), $sformatf("sat%0d", i));
        chk_cnt("sat", 15, 0);
        step(ctl(1,0,0,1, 1,1,0), "sat_pclr");
        step(ctl(0,0,0,0, 1,1,0), "sat_d1");
        chk_cnt("clr_wins", 0, 0);
        step(ctl(0,0,0,0, 1,1,0), "sat_d2");
        step(ctl(0,0,0,0, 0,0,0), "sat_d3");
        chk_cnt("post_clr", 2, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
